// File: rtl/program_loader_if.sv
// program_loader_if: nibble stream valid/ready handshake into the program loader.
interface program_loader_if #(parameter int DATA_W = 4);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   modport master (output in_valid, in_data, input in_ready);
   modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: loads the 16x4 CPU instruction store from a length/payload/checksum nibble stream.
module program_loader #(
   parameter int                DATA_W    = 4,
   parameter int                ADDR_W    = 4,
   parameter int                DEPTH     = 16,
   parameter logic [DATA_W-1:0] FILL_WORD = 4'hE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   program_loader_if.slave   s,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   loaded_len
);
   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, FILL, RUN, ERR} state_t;
   state_t            state, state_nx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] sum;
   logic              match, ready, xfer, last_data, last_fill;
   always_comb begin
      ready     = state inside {LEN, DATA, CSUM};
      xfer      = s.in_valid && ready;
      last_data = {1'b0, ptr} == loaded_len - (ADDR_W+1)'(1);
      last_fill = ptr == ADDR_W'(DEPTH-1);
      state_nx  = state;
      unique case (state)
         IDLE, RUN, ERR: state_nx = load_start ? LEN : state;
         LEN:            state_nx = xfer ? DATA : LEN;
         DATA:           state_nx = (xfer && last_data) ? CSUM : DATA;
         CSUM:           state_nx = !xfer ? CSUM : !loaded_len[ADDR_W] ? FILL : (s.in_data == sum) ? RUN : ERR;
         FILL:           state_nx = !last_fill ? FILL : match ? RUN : ERR;
         default:        state_nx = IDLE;
      endcase
   end
   assign s.in_ready  = ready;
   assign cpu_reset   = state != RUN;
   assign busy        = state inside {LEN, DATA, CSUM, FILL};
   assign done        = state == RUN;
   assign error       = state == ERR;
   assign fetch_instr = mem[fetch_addr];
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         sum        <= '0;
         match      <= 1'b0;
         loaded_len <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= FILL_WORD;
      end else begin
         state <= state_nx;
         unique case (state)
            LEN: if (xfer) begin
               loaded_len <= (s.in_data == '0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(s.in_data);
               ptr        <= '0;
               sum        <= '0;
            end
            DATA: if (xfer) begin
               mem[ptr] <= s.in_data;
               sum      <= sum + s.in_data;
               ptr      <= ptr + 1'b1;
            end
            CSUM: if (xfer) begin
               match <= s.in_data == sum;
               ptr   <= loaded_len[ADDR_W-1:0];
            end
            FILL: begin
               mem[ptr] <= FILL_WORD;
               ptr      <= ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
